// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer video read port between the scanout (master) and the RAM (slave)
interface vga_scanout_if #(
  parameter int WIDTH = 16
);
  logic [9:0]       pixel_x;
  logic [9:0]       pixel_y;
  logic [WIDTH-1:0] pixel_out;
  modport master (output pixel_x, output pixel_y, input pixel_out);
  modport slave  (input pixel_x, input pixel_y, output pixel_out);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing and 1-bpp framebuffer scanout
// VGA_BORDER_EN: when defined, active pixels at x>=512 show BORDER_COLOR instead of BG_COLOR
module vga_scanout #(
  parameter int          WIDTH                   = 16,
  parameter int          BITS_PER_MEMORY_PIXEL_X = 2,
  parameter int          BITS_PER_MEMORY_PIXEL_Y = 2,
  parameter int          CLK_DIV                 = 2,
  parameter int          H_ACTIVE                = 640,
  parameter int          H_FP                    = 16,
  parameter int          H_SYNC                  = 96,
  parameter int          H_BP                    = 48,
  parameter int          V_ACTIVE                = 480,
  parameter int          V_FP                    = 10,
  parameter int          V_SYNC                  = 2,
  parameter int          V_BP                    = 33,
  parameter logic [11:0] FG_COLOR                = 12'hFFF,
  parameter logic [11:0] BG_COLOR                = 12'h000,
  parameter logic [11:0] BORDER_COLOR            = 12'h00F
) (
  input  logic                 CPUclk,
  input  logic                 reset,
  vga_scanout_if.master        ram,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vblank
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] X_WRAP   = 10'd512;
`ifdef VGA_BORDER_EN
  localparam logic [11:0] HI_COLOR = BORDER_COLOR;
`else
  localparam logic [11:0] HI_COLOR = BG_COLOR;
`endif
  generate
    if (CLK_DIV < 2 || WIDTH != (1 << IW) || BITS_PER_MEMORY_PIXEL_X + BITS_PER_MEMORY_PIXEL_Y > 9) begin : g_bad_cfg
      $error("vga_scanout: need CLK_DIV>=2, power-of-two WIDTH and pixel scaling within 10-bit coordinates");
    end
  endgenerate
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic [11:0]   rgb_q, rgb_d, color;
  logic [IW-1:0] idx;
  logic          pix_en, h_wrap, active, pix_bit;
  // The RAM word for h_q/v_q arrives one CPUclk after the address, well before the next pix_en
  always_comb begin
    pix_en  = div_q == '0;
    h_wrap  = h_q == H_LAST;
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    h_d     = !pix_en ? h_q : h_wrap ? '0 : h_q + 10'd1;
    v_d     = !(pix_en && h_wrap) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
    idx     = IW'(h_q >> BITS_PER_MEMORY_PIXEL_X);
    pix_bit = ram.pixel_out[~idx];
    active  = h_q < H_ACT && v_q < V_ACT;
    color   = !active ? '0 : h_q >= X_WRAP ? HI_COLOR : pix_bit ? FG_COLOR : BG_COLOR;
    rgb_d   = pix_en ? color : rgb_q;
    hs_d    = pix_en ? !(h_q >= HS_START && h_q <= HS_END) : hs_q;
    vs_d    = pix_en ? !(v_q >= VS_START && v_q <= VS_END) : vs_q;
  end
  always_ff @(posedge CPUclk) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end
  assign ram.pixel_x           = h_q;
  assign ram.pixel_y           = v_q;
  assign vga_hs                = hs_q;
  assign vga_vs                = vs_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vblank                = v_q >= V_ACT;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of vga_scanout against a 1-clk registered RAM model
// Vertical timing is shortened (16/2/2/4 lines) so a whole frame fits in 38400 clocks
module tb_vga_scanout;
  logic        CPUclk = 1'b0;
  logic        reset  = 1'b1;
  logic        vga_hs, vga_vs, vblank;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [11:0] rgb;
  logic [15:0] mem [0:2047];
  int          checks   = 0;
  int          failures = 0;
`ifdef VGA_BORDER_EN
  localparam logic [11:0] BORDER = 12'h00F;
`else
  localparam logic [11:0] BORDER = 12'h000;
`endif

  vga_scanout_if #(.WIDTH(16)) ram ();

  vga_scanout #(.V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(4)) dut (
    .CPUclk(CPUclk), .reset(reset), .ram(ram),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vblank(vblank)
  );

  always #5 CPUclk = ~CPUclk;
  always @(posedge CPUclk) ram.pixel_out <= mem[{ram.pixel_y[9:2], ram.pixel_x[8:6]}];
  assign rgb = {vga_r, vga_g, vga_b};

  task fill(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  task do_reset(input int n);
    @(negedge CPUclk);
    reset = 1'b1;
    repeat (n) @(negedge CPUclk);
    reset = 1'b0;
  endtask

  task wait_addr(input int x, input int y);
    int n;
    n = 0;
    while ((ram.pixel_x !== 10'(x) || ram.pixel_y !== 10'(y)) && n < 50000) begin
      @(negedge CPUclk);
      n++;
    end
    if (n >= 50000) begin
      checks++;
      failures++;
      $display("FAIL wait_addr timeout x=%0d y=%0d got x=%0d y=%0d", x, y, ram.pixel_x, ram.pixel_y);
    end
  endtask

  // land on the sample point where the outputs show pixel (x,y)
  task at_px(input int x, input int y);
    wait_addr(x, y);
    repeat (2) @(negedge CPUclk);
  endtask

  task test_reset;
    fill(16'h0000);
    reset = 1'b1;
    repeat (5) @(negedge CPUclk);
    checks++;
    if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || rgb !== 12'h000 || vblank !== 1'b0 ||
        ram.pixel_x !== 10'd0 || ram.pixel_y !== 10'd0)
      begin failures++; $display("FAIL reset_state hs=%b vs=%b rgb=%h vbl=%b x=%0d y=%0d expected 1 1 000 0 0 0",
                                 vga_hs, vga_vs, rgb, vblank, ram.pixel_x, ram.pixel_y); end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CPUclk);
      checks++;
      if (ram.pixel_x !== 10'((k + 1) / 2))
        begin failures++; $display("FAIL px_step clk=%0d x=%0d expected %0d", k, ram.pixel_x, (k + 1) / 2); end
    end
    repeat (1594) @(negedge CPUclk);
    checks++;
    if (ram.pixel_x !== 10'd799 || ram.pixel_y !== 10'd0)
      begin failures++; $display("FAIL line_end x=%0d y=%0d expected 799 0", ram.pixel_x, ram.pixel_y); end
    @(negedge CPUclk);
    checks++;
    if (ram.pixel_x !== 10'd0 || ram.pixel_y !== 10'd1)
      begin failures++; $display("FAIL line_wrap x=%0d y=%0d expected 0 1", ram.pixel_x, ram.pixel_y); end
  endtask

  task test_frame;
    logic prev_hs, prev_vs;
    int   hs_start, vs_start, hs_falls, hs_rises, vs_falls, vbl_err;
    hs_start = 0; vs_start = 0; hs_falls = 0; hs_rises = 0; vs_falls = 0; vbl_err = 0;
    do_reset(5);
    prev_hs = vga_hs;
    prev_vs = vga_vs;
    for (int n = 1; n <= 38400; n++) begin
      @(negedge CPUclk);
      if (prev_hs && !vga_hs) begin
        hs_falls++; hs_start = n; checks++;
        if (ram.pixel_x !== 10'd657)
          begin failures++; $display("FAIL hs_fall x=%0d expected 657", ram.pixel_x); end
      end
      if (!prev_hs && vga_hs) begin
        hs_rises++; checks++;
        if (ram.pixel_x !== 10'd753 || n - hs_start !== 192)
          begin failures++; $display("FAIL hs_rise x=%0d width=%0d expected 753 192", ram.pixel_x, n - hs_start); end
      end
      if (prev_vs && !vga_vs) begin
        vs_falls++; vs_start = n; checks++;
        if (ram.pixel_x !== 10'd1 || ram.pixel_y !== 10'd18)
          begin failures++; $display("FAIL vs_fall x=%0d y=%0d expected 1 18", ram.pixel_x, ram.pixel_y); end
      end
      if (!prev_vs && vga_vs) begin
        checks++;
        if (ram.pixel_x !== 10'd1 || ram.pixel_y !== 10'd20 || n - vs_start !== 3200)
          begin failures++; $display("FAIL vs_rise x=%0d y=%0d width=%0d expected 1 20 3200",
                                     ram.pixel_x, ram.pixel_y, n - vs_start); end
      end
      if (vblank !== (ram.pixel_y >= 10'd16)) vbl_err++;
      if (n == 38398) begin
        checks++;
        if (ram.pixel_x !== 10'd799 || ram.pixel_y !== 10'd23)
          begin failures++; $display("FAIL frame_end x=%0d y=%0d expected 799 23", ram.pixel_x, ram.pixel_y); end
      end
      if (n == 38399) begin
        checks++;
        if (ram.pixel_x !== 10'd0 || ram.pixel_y !== 10'd0)
          begin failures++; $display("FAIL frame_wrap x=%0d y=%0d expected 0 0", ram.pixel_x, ram.pixel_y); end
      end
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
    checks++;
    if (hs_falls !== 24 || hs_rises !== 24 || vs_falls !== 1)
      begin failures++; $display("FAIL sync_counts hs_falls=%0d hs_rises=%0d vs_falls=%0d expected 24 24 1",
                                 hs_falls, hs_rises, vs_falls); end
    checks++;
    if (vbl_err !== 0) begin failures++; $display("FAIL vblank_track errors=%0d expected 0", vbl_err); end
  endtask

  task test_word_msb;
    fill(16'h0000);
    mem[0] = 16'hF000;
    mem[8] = 16'h0F00;
    do_reset(5);
    for (int x = 0; x < 64; x++) begin
      at_px(x, 0);
      checks++;
      if (rgb !== ((x < 16) ? 12'hFFF : 12'h000))
        begin failures++; $display("FAIL line0 x=%0d rgb=%h expected %h", x, rgb, (x < 16) ? 12'hFFF : 12'h000); end
    end
    for (int y = 1; y < 4; y++) begin
      at_px(15, y);
      checks++;
      if (rgb !== 12'hFFF) begin failures++; $display("FAIL row_rep y=%0d x=15 rgb=%h expected fff", y, rgb); end
      at_px(16, y);
      checks++;
      if (rgb !== 12'h000) begin failures++; $display("FAIL row_rep y=%0d x=16 rgb=%h expected 000", y, rgb); end
    end
    at_px(15, 4);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL row1 x=15 rgb=%h expected 000", rgb); end
    at_px(16, 4);
    checks++;
    if (rgb !== 12'hFFF) begin failures++; $display("FAIL row1 x=16 rgb=%h expected fff", rgb); end
    at_px(31, 4);
    checks++;
    if (rgb !== 12'hFFF) begin failures++; $display("FAIL row1 x=31 rgb=%h expected fff", rgb); end
    at_px(32, 4);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL row1 x=32 rgb=%h expected 000", rgb); end
  endtask

  task test_word_lsb_latency;
    fill(16'h0000);
    mem[0] = 16'h0001;
    do_reset(5);
    at_px(59, 0);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL lsb x=59 rgb=%h expected 000", rgb); end
    wait_addr(60, 0);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL lag0 rgb=%h expected 000", rgb); end
    @(negedge CPUclk);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL lag1 rgb=%h expected 000", rgb); end
    @(negedge CPUclk);
    checks++;
    if (rgb !== 12'hFFF) begin failures++; $display("FAIL lag2 rgb=%h expected fff", rgb); end
    for (int x = 61; x < 66; x++) begin
      at_px(x, 0);
      checks++;
      if (rgb !== ((x < 64) ? 12'hFFF : 12'h000))
        begin failures++; $display("FAIL lsb x=%0d rgb=%h expected %h", x, rgb, (x < 64) ? 12'hFFF : 12'h000); end
    end
  endtask

  task test_border;
    int          xs [9];
    logic [11:0] ex [9];
    xs = '{510, 511, 512, 600, 639, 640, 700, 752, 799};
    ex = '{12'hFFF, 12'hFFF, BORDER, BORDER, BORDER, 12'h000, 12'h000, 12'h000, 12'h000};
    fill(16'hFFFF);
    do_reset(5);
    for (int i = 0; i < 9; i++) begin
      at_px(xs[i], 0);
      checks++;
      if (rgb !== ex[i]) begin failures++; $display("FAIL border x=%0d rgb=%h expected %h", xs[i], rgb, ex[i]); end
    end
    at_px(639, 15);
    checks++;
    if (rgb !== BORDER) begin failures++; $display("FAIL border_last y=15 rgb=%h expected %h", rgb, BORDER); end
    at_px(0, 16);
    checks++;
    if (rgb !== 12'h000 || vblank !== 1'b1)
      begin failures++; $display("FAIL vblank_line rgb=%h vbl=%b expected 000 1", rgb, vblank); end
  endtask

  task test_reset_mid_frame;
    fill(16'hFFFF);
    wait_addr(300, 10);
    reset = 1'b1;
    @(negedge CPUclk);
    checks++;
    if (ram.pixel_x !== 10'd0 || ram.pixel_y !== 10'd0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 ||
        rgb !== 12'h000 || vblank !== 1'b0)
      begin failures++; $display("FAIL mid_reset x=%0d y=%0d hs=%b vs=%b rgb=%h vbl=%b expected 0 0 1 1 000 0",
                                 ram.pixel_x, ram.pixel_y, vga_hs, vga_vs, rgb, vblank); end
    reset = 1'b0;
    @(negedge CPUclk);
    checks++;
    if (ram.pixel_x !== 10'd1) begin failures++; $display("FAIL restart_x x=%0d expected 1", ram.pixel_x); end
    @(negedge CPUclk);
    checks++;
    if (rgb !== 12'hFFF) begin failures++; $display("FAIL restart_px0 rgb=%h expected fff", rgb); end
    repeat (1597) @(negedge CPUclk);
    checks++;
    if (ram.pixel_x !== 10'd0 || ram.pixel_y !== 10'd1)
      begin failures++; $display("FAIL restart_wrap x=%0d y=%0d expected 0 1", ram.pixel_x, ram.pixel_y); end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_word_msb;
    test_word_lsb_latency;
    test_border;
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
